// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath and its display: result width,
// conversion FSM states and 7-segment codes.
package cpu_pkg;

    // Width of the ALU result bus (q).
    localparam int RESULT_W = 14;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIM  = 2'd2
    } conv_state_t;

    // Active-high segment codes, ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment code of one BCD digit; codes 10..15 are not digits and stay dark.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // when doubled, so pre-add 3 to carry it into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to 7-segment decoder with a blanking input.
module seg7_dec
    import cpu_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the digit; non-decimal codes decode dark.
    always_comb begin
        seg = blank ? SEG_BLANK : seg_code(digit);
    end

endmodule

// File: rtl/resultado_display.sv
// Converts the signed ALU result into sign + four BCD digits with a
// sequential double-dabble engine, and scans them onto a multiplexed
// 4-digit 7-segment display with leading-zero blanking.
module resultado_display
    import cpu_pkg::*;
#(
    parameter int W        = RESULT_W,
    parameter int SCAN_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] valor,
    output logic         busy,
    output logic         done,
    output logic         sinal,
    output logic [15:0]  bcd,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         led_menos
);

    // One shift per magnitude bit; the last iteration has count W-1.
    localparam logic [3:0] LAST_ITER = 4'(W - 1);
    localparam int         DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    conv_state_t  state, state_n;
    logic [3:0]   iter;
    logic [W-1:0] mag;
    logic [15:0]  work_bcd;
    logic [15:0]  adj_bcd;
    logic         sinal_n;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx;
    logic [3:0]       cur_digit;
    logic             cur_blank;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every
        // register samples the pre-edge values, independent of block order.
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state logic: IDLE -> CONV on start, CONV for W iterations, FIM for one cycle.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_n = state;
        case (state)
            ST_IDLE: if (start)             state_n = ST_CONV;
            ST_CONV: if (iter == LAST_ITER) state_n = ST_FIM;
            ST_FIM:                         state_n = ST_IDLE;
            default:                        state_n = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to each digit before the shift.
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < 4; i++) begin
            adj_bcd[i*4 +: 4] = add3(work_bcd[i*4 +: 4]);
        end
    end

    // Conversion datapath: capture magnitude, shift-and-correct, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter     <= '0;
            mag      <= '0;
            work_bcd <= '0;
            sinal_n  <= 1'b0;
            bcd      <= '0;
            sinal    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sinal_n  <= valor[W-1];
                        // -8192 negates to 14'h2000, which is the right unsigned magnitude.
                        mag      <= valor[W-1] ? (~valor + 1'b1) : valor;
                        work_bcd <= '0;
                        iter     <= '0;
                    end
                end
                ST_CONV: begin
                    {work_bcd, mag} <= {adj_bcd, mag} << 1;
                    iter            <= iter + 4'd1;
                end
                ST_FIM: begin
                    bcd   <= work_bcd;
                    sinal <= sinal_n;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign led_menos = sinal;

    // Free-running scan divider; the digit slot advances on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx   <= 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx   <= idx + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Select the scanned digit and blank leading zeros (units digit never blanks).
    always_comb begin
        an        = 4'b0001 << idx;
        cur_digit = bcd[{idx, 2'b00} +: 4];
        case (idx)
            2'd1:    cur_blank = (bcd[15:4]  == 12'h000);
            2'd2:    cur_blank = (bcd[15:8]  == 8'h00);
            2'd3:    cur_blank = (bcd[15:12] == 4'h0);
            default: cur_blank = 1'b0;
        endcase
    end

    seg7_dec u_seg7_dec (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg)
    );

endmodule

// File: tb/tb_resultado_display.sv
// Self-checking bench for resultado_display: table-driven conversions plus
// hand-written sequences for busy, reset, scan and back-to-back corners.
module tb_resultado_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] valor;
    logic        busy, done, sinal, led_menos;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;

    resultado_display #(.W(14), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .valor     (valor),
        .busy      (busy),
        .done      (done),
        .sinal     (sinal),
        .bcd       (bcd),
        .an        (an),
        .seg       (seg),
        .led_menos (led_menos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] valor;
        logic [15:0] bcd;
        logic        sinal;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference BCD by decimal arithmetic.
    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [13:0] f_val(input int e);
        return 14'(100 + 37 * e);
    endfunction

    // One conversion with latency, result and done-width checks.
    task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic es, input string tag);
        int lat;
        lat   = 0;
        valor = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_rise"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (done) lat = k;
        end
        check({tag, " latency"}, 32'(lat), 32'd15);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " bcd"}, 32'(bcd), 32'(eb));
        check({tag, " sinal"}, 32'(sinal), 32'(es));
        check({tag, " led_menos"}, 32'(led_menos), 32'(es));
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int ndone;
        int found;
        logic [3:0] prev_an;
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];

        vecs[0] = '{14'd123,  16'h0123, 1'b0};
        vecs[1] = '{14'h3000, 16'h4096, 1'b1};
        vecs[2] = '{14'h2000, 16'h8192, 1'b1};
        vecs[3] = '{14'h1FFF, 16'h8191, 1'b0};
        vecs[4] = '{14'h3FFF, 16'h0001, 1'b1};
        vecs[5] = '{14'd0,    16'h0000, 1'b0};
        vecs[6] = '{14'h3F9C, 16'h0100, 1'b1};
        vecs[7] = '{14'h3C18, 16'h1000, 1'b1};
        vecs[8] = '{14'd42,   16'h0042, 1'b0};

        exp_an[0] = 4'b0001; exp_seg[0] = 7'h5B;
        exp_an[1] = 4'b0010; exp_seg[1] = 7'h66;
        exp_an[2] = 4'b0100; exp_seg[2] = 7'h00;
        exp_an[3] = 4'b1000; exp_seg[3] = 7'h00;

        // Reset state.
        rst = 1'b1; start = 1'b0; valor = '0;
        tick(); tick();
        check("rst busy",      32'(busy),      32'd0);
        check("rst done",      32'(done),      32'd0);
        check("rst sinal",     32'(sinal),     32'd0);
        check("rst bcd",       32'(bcd),       32'd0);
        check("rst led_menos", 32'(led_menos), 32'd0);
        check("rst an",        32'(an),        32'h1);
        check("rst seg",       32'(seg),       32'h3F);
        rst = 1'b0;
        tick();

        // Table of conversions.
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].valor, vecs[i].bcd, vecs[i].sinal, $sformatf("vec%0d", i));
        end

        // Display scan with bcd = 0042: find start of slot 0, then watch 16 cycles.
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            prev_an = an;
            tick();
            if (prev_an == 4'b1000 && an == 4'b0001) found = 1;
        end
        check("scan sync", 32'(found), 32'd1);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("scan an c%0d", c),  32'(an),  32'(exp_an[c/4]));
            check($sformatf("scan seg c%0d", c), 32'(seg), 32'(exp_seg[c/4]));
            tick();
        end

        // start re-pulsed at cycle 5 of a conversion is ignored.
        valor = 14'd777; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        valor = 14'd555; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 6; k <= 25 && lat == 0; k++) begin
            tick();
            if (done) lat = k;
        end
        check("busy_ignore latency", 32'(lat), 32'd15);
        check("busy_ignore bcd",     32'(bcd), 32'h0777);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        check("busy_ignore no_second_done", 32'(ndone), 32'd0);

        // rst at cycle 7 aborts the conversion.
        valor = 14'd321; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy",  32'(busy),  32'd0);
        check("abort bcd",   32'(bcd),   32'd0);
        check("abort sinal", 32'(sinal), 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);

        // rst wins over start on the same edge.
        valor = 14'd5; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio busy", 32'(busy), 32'd0);
        tick();
        check("rst_prio busy_after", 32'(busy), 32'd0);

        // start held high: one conversion per 16 cycles, each from its accepting edge.
        valor = f_val(0); start = 1'b1;
        for (int e = 0; e < 48; e++) begin
            tick();
            valor = f_val(e + 1);
            check($sformatf("b2b done e%0d", e), 32'(done), 32'((e % 16) == 15));
            if (e % 16 == 15) begin
                check($sformatf("b2b bcd e%0d", e), 32'(bcd), 32'(to_bcd(int'(f_val(e - 15)))));
                check($sformatf("b2b sinal e%0d", e), 32'(sinal), 32'd0);
            end
        end
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/resultado_display.md
# resultado_display

Converts the 14-bit two's-complement ALU result into a sign flag and four BCD digits using a sequential double-dabble engine with a start/done handshake. It drives a multiplexed 4-digit 7-segment display with leading-zero blanking. It sits downstream of the `operacoes` ALU on the `q` bus, decoding what the ALU encodes. It replaces the raw `led_sinal`/`led_valor` LEDs on the board.

## Interface
- `W`, 14: input result width. Fixed by the ALU result bus; other values unsupported.
- `SCAN_DIV`, 50000: clock cycles per display digit slot. Must be ≥ 2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request conversion of `valor`. Sampled only in IDLE.
- `valor` in 14: two's-complement value, normally ALU `q`. Sampled on the accepting edge only.
- `busy` out 1: conversion in progress.
- `done` out 1: single-cycle pulse when new `bcd`/`sinal` are valid.
- `sinal` out 1: 1 when the last converted value was negative.
- `bcd` out 16: four BCD digits of the magnitude. `bcd[3:0]` is the units digit.
- `an` out 4: one-hot, active-high digit enable. `an[0]` is the units digit.
- `seg` out 7: active-high segments, ordered {g,f,e,d,c,b,a}.
- `led_menos` out 1: minus indicator, equal to `sinal`.

## Operation
States are IDLE, CONV and FIM.

**IDLE**
- When `start`=1, capture `sinal_n = valor[13]`.
- Capture `mag = sinal_n ? (~valor + 1) : valor` as a 14-bit unsigned value. -8192 yields 14'h2000, which is correct as unsigned.
- Clear the 16-bit working BCD register. Set iteration count to 0 and go to CONV.

**CONV** (14 cycles)
- For each 4-bit digit of the working register, add 3 if the digit is ≥ 5.
- Then shift {work_bcd, mag} left by 1.
- After the iteration with count 13, go to FIM.

**FIM**
- Register `bcd <= work_bcd` and `sinal <= sinal_n`.
- Assert `done` for the following cycle. Return to IDLE.

**Handshake and output rules**
- `start` while `busy` is ignored: not queued, no effect.
- `bcd`/`sinal` hold the previous result during CONV, so the display never shows partial values.
- Maximum magnitude is 8192, so four digits always suffice and no overflow is possible.

**Display scan**
- Free-running divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- `an = 1 << idx`.
- `seg` is the 7-segment code of digit `idx` of `bcd`.
- Blanking: digit `idx` > 0 shows blank (7'h00) if it and all higher digits are 0. Digit 0 is never blanked.
- Codes, 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- Illegal BCD values 10–15 display blank.

## Timing
- `start` sampled at edge N. CONV runs on edges N+1..N+14, FIM is the state after edge N+14, and outputs update at edge N+15.
- `done`=1 during cycle N+15 to N+16 only.
- `busy`=1 from after edge N until edge N+15. `busy`=0 while `done`=1.
- `start` high during the `done` cycle is accepted at edge N+16. Back-to-back throughput is 1 conversion per 16 cycles.
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `sinal`=0, `bcd`=0, `led_menos`=0
  - divider 0, idx 0, `an`=4'b0001, `seg`=7'h3F
- `rst` mid-conversion aborts with no `done`. `bcd`/`sinal` return to 0.
- `rst` has priority over `start` on the same edge.
- Scan outputs are registered or decoded from registered state only. `seg` changes on the same edge as `an`.

## Structure
- Shared `cpu_pkg`:
  - state encoding (IDLE, CONV, FIM)
  - 7-segment code constants for 0–9 and `SEG_BLANK`
  - result width constant 14, shared with the ALU
- Sub-module `seg7_dec`: combinational, 4-bit BCD plus blank input to 7-bit segments. It is reused elsewhere on the board.
- Conversion FSM and scan counter stay in `resultado_display`.

## Test plan
1. `valor`=14'd123, pulse `start`: `busy` rises next cycle. `done` comes exactly 15 cycles after the `start` edge, with `bcd`=16'h0123 and `sinal`=0.
2. `valor`=14'h3000 (-4096, i.e. -64×64 wrapped): `bcd`=16'h4096, `sinal`=1, `led_menos`=1.
3. Boundaries:
   - `valor`=14'h2000 (-8192) gives `bcd`=16'h8192, `sinal`=1.
   - `valor`=14'h1FFF gives `bcd`=16'h8191, `sinal`=0.
   - `valor`=14'h3FFF (-1) gives `bcd`=16'h0001, `sinal`=1.
4. Busy and reset:
   - Re-pulse `start` at cycle 5 of a conversion with a different `valor`: ignored, and the first result is delivered.
   - Assert `rst` at cycle 7 of a conversion: `busy`=0 next cycle, no `done`, `bcd`=0.
5. `SCAN_DIV`=4, `bcd`=16'h0042:
   - `an` steps 0001→0010→0100→1000→0001, 4 cycles per slot.
   - `seg` is 5B, 66, 00, 00 respectively.
6. `start` held continuously with changing `valor`: conversions occur every 16 cycles. Each `done` reflects the `valor` present at its accepting edge.
